// File: rtl/seg595_pkg.sv
// Shared constants for the 74HC595 link receiver: active-low 7-segment
// glyph table, link FSM state encoding and default frame length.
package seg595_pkg;

  localparam int FRAME_BITS_DEF = 16;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_A     = 8'h88;
  localparam logic [7:0] SEG_B     = 8'h83;
  localparam logic [7:0] SEG_C     = 8'hC6;
  localparam logic [7:0] SEG_D     = 8'hA1;
  localparam logic [7:0] SEG_E     = 8'h86;
  localparam logic [7:0] SEG_F     = 8'h8E;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry k is the active-low glyph (dp off) for hex digit k.
  localparam logic [15:0][7:0] SEG_TABLE = {
    SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
    SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OVER  = 2'd2,
    LATCH = 2'd3
  } link_state_t;

endpackage

// File: rtl/seg7_pattern_dec.sv
// Decodes one 8-bit segment pattern {dp,g,f,e,d,c,b,a} back to a hex digit;
// dp is ignored, unknown patterns (including blank) give valid=0, value=0.
module seg7_pattern_dec
  import seg595_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [7:0] pattern,
  output logic [3:0] value,
  output logic       valid
);

  logic [7:0] norm;

  always_comb begin
    norm  = ACTIVE_LOW ? pattern : ~pattern;
    value = 4'h0;
    valid = 1'b0;
    // Forcing dp "off" makes the decimal point irrelevant to the match.
    for (int k = 0; k < 16; k++) begin
      if ((norm | 8'h80) == SEG_TABLE[k]) begin
        value = 4'(k);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seg595_link_rx.sv
// Receiver/decoder for the 3-wire 74HC595 display link (sclk, rclk, dio).
// Optional input glitch filter: define SEG595_GLITCH_FILTER_EN.
module seg595_link_rx
  import seg595_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FRAME_BITS     = FRAME_BITS_DEF,
  parameter int FILT_LEN       = 3,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk,
  input  logic        rclk,
  input  logic        dio,
  output logic [63:0] seg_flat,
  output logic [31:0] val_flat,
  output logic [7:0]  dig_valid,
  output logic        frame_strobe,
  output logic        frame_err,
  output logic        sel_err,
  output logic [15:0] frame_cnt
);

  localparam int               CNT_W     = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVER  = CNT_W'(FRAME_BITS + 1);
  localparam logic [63:0]      IMG_BLANK = (SEG_ACTIVE_LOW != 0) ? {64{1'b1}} : {64{1'b0}};

  if (SYNC_STAGES < 2 || FILT_LEN < 1) begin : g_bad_params
    $error("seg595_link_rx: SYNC_STAGES must be >= 2 and FILT_LEN >= 1");
  end

  logic [2:0]                   pin_p0;
  logic [SYNC_STAGES-1:0][2:0]  sync_p1;
  logic [2:0]                   line_p1;
  logic [1:0]                   dly_p2;
  logic                         sclk_rise;
  logic                         rclk_rise;
  logic                         dio_bit;

  link_state_t      state;
  logic [CNT_W-1:0] bit_cnt;
  logic [15:0]      shreg;

  assign pin_p0 = {sclk, rclk, dio};

  // Stage p1: synchroniser chain, newest sample in index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p1 <= '0;
    end else begin
      sync_p1 <= {sync_p1[SYNC_STAGES-2:0], pin_p0};
    end
  end

`ifdef SEG595_GLITCH_FILTER_EN
  localparam int FC_W = $clog2(FILT_LEN + 1);

  logic [2:0]           filt_q;
  logic [2:0][FC_W-1:0] filt_cnt;

  // The filtered level flips on the FILT_LEN-th consecutive differing sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      filt_q   <= '0;
      filt_cnt <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync_p1[SYNC_STAGES-1][i] == filt_q[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FC_W'(FILT_LEN - 1)) begin
          filt_q[i]   <= sync_p1[SYNC_STAGES-1][i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign line_p1 = filt_q;
`else
  assign line_p1 = sync_p1[SYNC_STAGES-1];
`endif

  // Stage p2: one-cycle delay of the clock lines for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_p2 <= '0;
    end else begin
      dly_p2 <= line_p1[2:1];
    end
  end

  assign sclk_rise = line_p1[2] & ~dly_p2[1];
  assign rclk_rise = line_p1[1] & ~dly_p2[0];
  assign dio_bit   = line_p1[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      seg_flat     <= IMG_BLANK;
      frame_strobe <= 1'b0;
      frame_err    <= 1'b0;
      sel_err      <= 1'b0;
      frame_cnt    <= '0;
    end else begin
      frame_strobe <= 1'b0;
      if (state == LATCH) begin
        state   <= IDLE;
        bit_cnt <= '0;
        if (bit_cnt != CNT_FULL) begin
          frame_err <= 1'b1;
        end else if (shreg[7:0] == 8'h00) begin
          sel_err <= 1'b1;
        end else begin
          for (int i = 0; i < 8; i++) begin
            if (shreg[i]) seg_flat[8*i +: 8] <= shreg[15:8];
          end
          frame_strobe <= 1'b1;
          frame_cnt    <= frame_cnt + 16'd1;
        end
      end else begin
        if (sclk_rise) begin
          shreg <= {shreg[14:0], dio_bit};
          if (bit_cnt != CNT_OVER) bit_cnt <= bit_cnt + 1'b1;
          state <= (bit_cnt >= CNT_FULL) ? OVER : SHIFT;
        end
        // A coincident sclk edge has already been shifted in above.
        if (rclk_rise) state <= LATCH;
      end
    end
  end

  for (genvar d = 0; d < 8; d++) begin : g_dec
    seg7_pattern_dec #(
      .ACTIVE_LOW(SEG_ACTIVE_LOW != 0)
    ) u_dec (
      .pattern(seg_flat[8*d +: 8]),
      .value  (val_flat[4*d +: 4]),
      .valid  (dig_valid[d])
    );
  end

endmodule

// File: tb/tb_seg595_link_rx.sv
// Randomised bench for seg595_link_rx against a frame-level reference model.
// Also exercises the glitch filter when SEG595_GLITCH_FILTER_EN is defined.
`timescale 1ns/1ps
module tb_seg595_link_rx;

  localparam int SYNC = 2;
`ifdef SEG595_GLITCH_FILTER_EN
  localparam int FILT = 3;
`else
  localparam int FILT = 0;
`endif
  localparam int LAT  = SYNC + 2 + FILT;
  localparam int HOLD = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sclk = 1'b0;
  logic        rclk = 1'b0;
  logic        dio = 1'b0;
  logic [63:0] seg_flat;
  logic [31:0] val_flat;
  logic [7:0]  dig_valid;
  logic        frame_strobe;
  logic        frame_err;
  logic        sel_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Glyphs for hex 0..F as listed in the link documentation (active-low).
  localparam logic [7:0] PAT [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic [7:0]  m_img [8];
  logic [15:0] m_cnt;
  logic        m_ferr;
  logic        m_serr;

  seg595_link_rx dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .rclk        (rclk),
    .dio         (dio),
    .seg_flat    (seg_flat),
    .val_flat    (val_flat),
    .dig_valid   (dig_valid),
    .frame_strobe(frame_strobe),
    .frame_err   (frame_err),
    .sel_err     (sel_err),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 8; d++) m_img[d] = 8'hFF;
    m_cnt  = '0;
    m_ferr = 1'b0;
    m_serr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    logic [63:0] e_seg;
    logic [31:0] e_val;
    logic [7:0]  e_vld;
    e_seg = '0;
    e_val = '0;
    e_vld = '0;
    for (int d = 0; d < 8; d++) begin
      e_seg[8*d +: 8] = m_img[d];
      for (int k = 0; k < 16; k++) begin
        if ({1'b1, m_img[d][6:0]} == PAT[k]) begin
          e_val[4*d +: 4] = 4'(k);
          e_vld[d]        = 1'b1;
        end
      end
    end
    chk({tag, ".seg"}, seg_flat, e_seg);
    chk({tag, ".val"}, 64'(val_flat), 64'(e_val));
    chk({tag, ".vld"}, 64'(dig_valid), 64'(e_vld));
    chk({tag, ".cnt"}, 64'(frame_cnt), 64'(m_cnt));
    chk({tag, ".ferr"}, 64'(frame_err), 64'(m_ferr));
    chk({tag, ".serr"}, 64'(sel_err), 64'(m_serr));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    dio = b;
    idle(2);
    sclk = 1'b1;
    idle(HOLD);
    sclk = 1'b0;
    idle(HOLD - 2);
  endtask

  task automatic send_bits(input logic [31:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(data[i]);
  endtask

  // Shift n bits, pulse rclk, then compare strobe count, latency and state.
  task automatic do_frame(input string tag, input logic [31:0] data, input int n);
    int n_str;
    int lat;
    bit accept;
    n_str  = 0;
    lat    = 0;
    accept = 1'b0;
    send_bits(data, n);
    if (n != 16) begin
      m_ferr = 1'b1;
    end else if (data[7:0] == 8'h00) begin
      m_serr = 1'b1;
    end else begin
      for (int d = 0; d < 8; d++) if (data[d]) m_img[d] = data[15:8];
      m_cnt  = m_cnt + 16'd1;
      accept = 1'b1;
    end
    @(negedge clk);
    rclk = 1'b1;
    for (int k = 1; k <= 3 * HOLD; k++) begin
      @(posedge clk);
      #1;
      if (frame_strobe) begin
        n_str++;
        if (lat == 0) lat = k;
      end
      if (k == HOLD) rclk = 1'b0;
    end
    chk({tag, ".strobes"}, 64'(n_str), accept ? 64'd1 : 64'd0);
    if (accept) chk({tag, ".latency"}, 64'(lat), 64'(LAT));
    check_state(tag);
  endtask

  initial begin
    model_reset();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_state("reset");
    chk("reset.strobe", 64'(frame_strobe), 64'd0);
    rst = 1'b1;
    idle(4);

    do_frame("f904", 32'h0000_F904, 16);
    chk("f904.val2", 64'(val_flat[11:8]), 64'h1);
    chk("f904.vld", 64'(dig_valid), 64'h04);

    for (int k = 0; k < 8; k++) begin
      do_frame("digk", {16'h0, PAT[k], 8'(1 << k)}, 16);
    end
    chk("digk.valflat", 64'(val_flat), 64'h7654_3210);
    chk("digk.vldall", 64'(dig_valid), 64'hFF);
    chk("digk.cnt", 64'(frame_cnt), 64'd9);

    do_frame("short15", 32'h0000_3F01, 15);
    chk("short15.ferr", 64'(frame_err), 64'd1);
    do_frame("long17", 32'h0001_8E02, 17);

    do_frame("sel0", 32'h0000_9200, 16);
    chk("sel0.serr", 64'(sel_err), 64'd1);
    do_frame("multi", 32'h0000_8681, 16);
    chk("multi.d0", 64'(val_flat[3:0]), 64'hE);
    chk("multi.d7", 64'(val_flat[31:28]), 64'hE);

    for (int r = 0; r < 30; r++) begin
      int n_sel;
      int p_sel;
      logic [31:0] data;
      n_sel = $urandom_range(0, 4);
      p_sel = $urandom_range(0, 15);
      data  = $urandom;
      if ($urandom_range(0, 3) != 0) data[15:8] = PAT[p_sel];
      if ($urandom_range(0, 5) == 0) data[7:0] = 8'h00;
      do_frame("rand", data, (n_sel == 0) ? 15 : (n_sel == 4) ? 17 : 16);
    end

    send_bits(32'h0000_01AB, 9);
    rst = 1'b0;
    model_reset();
    idle(3);
    check_state("midrst");
    rst = 1'b1;
    idle(4);
    do_frame("c001", 32'h0000_C001, 16);
    chk("c001.d0", 64'(val_flat[3:0]), 64'h0);
    chk("c001.ferr", 64'(frame_err), 64'd0);

`ifdef SEG595_GLITCH_FILTER_EN
    sclk = 1'b1;
    idle(1);
    sclk = 1'b0;
    idle(10);
    do_frame("glitch", 32'h0000_A410, 16);
    chk("glitch.ferr", 64'(frame_err), 64'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
